// File: rtl/dispatch_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_pkg
// Shared definitions for the dispatch scheduler: decoder opClass encodings,
// the reservation-station selector enum and the class-to-station mapping.
// -----------------------------------------------------------------------------
package dispatch_pkg;

  localparam logic [6:0] ClassLUI   = 7'b0110111;
  localparam logic [6:0] ClassAUIPC = 7'b0010111;
  localparam logic [6:0] ClassJAL   = 7'b1101111;
  localparam logic [6:0] ClassJALR  = 7'b1100111;
  localparam logic [6:0] ClassB     = 7'b1100011;
  localparam logic [6:0] ClassLD    = 7'b0000011;
  localparam logic [6:0] ClassST    = 7'b0100011;
  localparam logic [6:0] ClassRI    = 7'b0010011;
  localparam logic [6:0] ClassRR    = 7'b0110011;
  localparam logic [6:0] ClassNOP   = 7'b0000000;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ALU  = 2'd1,
    LS   = 2'd2,
    BR   = 2'd3
  } rs_sel;

  // Unknown encodings map to NONE so they are dropped without using credit.
  function automatic rs_sel class_to_rs(input logic [6:0] cls);
    rs_sel r;
    case (cls)
      ClassLUI, ClassAUIPC, ClassJAL, ClassJALR, ClassRI, ClassRR: r = ALU;
      ClassLD, ClassST:                                            r = LS;
      ClassB:                                                      r = BR;
      default:                                                     r = NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_credit_counter.sv
// -----------------------------------------------------------------------------
// credit_counter
// Free-slot counter for one reservation station. Starts full (SIZE credits),
// loses one credit per dispatch and regains freeNum credits per cycle.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset (credit <= SIZE)
//   rdy       : global enable; counter holds when low
//   take      : one instruction dispatched to this RS this cycle
//   freeNum   : entries released by the RS this cycle (incl. squashed ones)
//   credit    : current (start-of-cycle) free slot count
//   avail     : credit != 0
// -----------------------------------------------------------------------------
module credit_counter #(
  parameter int SIZE = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        take,
  input  logic [$clog2(SIZE+1)-1:0]   freeNum,
  output logic [$clog2(SIZE+1)-1:0]   credit,
  output logic                        avail
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW:0] SIZE_X = (CW + 1)'(SIZE);

  // One extra bit so an over-return or an underflow is visible to the checks
  // below instead of silently wrapping.
  logic [CW:0] nxt_x;

  always_comb begin
    nxt_x = {1'b0, credit} - {{CW{1'b0}}, take} + {1'b0, freeNum};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit <= CW'(SIZE);
    end else if (rdy) begin
      credit <= nxt_x[CW-1:0];
    end
  end

  assign avail = (credit != '0);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      assert ({1'b0, freeNum} <= (SIZE_X - {1'b0, credit}))
        else $error("credit_counter: freeNum %0d exceeds occupancy (credit %0d, size %0d)",
                    freeNum, credit, SIZE);
      assert (!(take && !avail))
        else $error("credit_counter: dispatch with zero credit");
      assert (nxt_x <= SIZE_X)
        else $error("credit_counter: credit would exceed size %0d", SIZE);
    end
  end
`endif

endmodule

// File: rtl/dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// dispatch_ctrl
// Dispatch scheduler between the decoder and the ALU, load/store and branch
// reservation stations. Each decoded instruction is routed by opClass to its
// RS if that RS has a free slot (credit); otherwise it is parked in a single
// skid register and the decoder is stalled until it can go. A mispredict
// (misTaken) drops the skid entry and the current input.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rdy             : global enable; all state holds while low
//   misTaken        : branch mispredict flush
//   inClass         : decoder opClass (ClassNOP = no instruction)
//   inPayload       : opaque decoder payload
//   stall           : combinational hold to the decoder
//   aluEn/lsEn/brEn : registered one-cycle RS write strobes
//   outPayload      : registered payload, valid while any strobe is high
//   aluFreeNum      : ALU RS entries released this cycle
//   lsFreeNum       : LS RS entries released this cycle
//   brFreeNum       : branch RS entries released this cycle
// -----------------------------------------------------------------------------
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int ALU_SIZE = 8,
  parameter int LS_SIZE  = 8,
  parameter int BR_SIZE  = 4,
  parameter int PAY_W    = 128
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy,
  input  logic                            misTaken,
  input  logic [6:0]                      inClass,
  input  logic [PAY_W-1:0]                inPayload,
  output logic                            stall,
  output logic                            aluEn,
  output logic                            lsEn,
  output logic                            brEn,
  output logic [PAY_W-1:0]                outPayload,
  input  logic [$clog2(ALU_SIZE+1)-1:0]   aluFreeNum,
  input  logic [$clog2(LS_SIZE+1)-1:0]    lsFreeNum,
  input  logic [$clog2(BR_SIZE+1)-1:0]    brFreeNum
);

  localparam int AW = $clog2(ALU_SIZE + 1);
  localparam int LW = $clog2(LS_SIZE + 1);
  localparam int BW = $clog2(BR_SIZE + 1);

  // Credit state
  logic [AW-1:0] cA;
  logic [LW-1:0] cL;
  logic [BW-1:0] cB;
  logic          availA, availL, availB;

  // Skid register: one parked instruction whose RS was full
  logic             sv;
  logic [6:0]       sClass;
  logic [PAY_W-1:0] sPay;

  // Stage p0: candidate selection and dispatch decision
  rs_sel            in_rs_p0;
  rs_sel            sk_rs_p0;
  rs_sel            cand_rs_p0;
  logic [PAY_W-1:0] cand_pay_p0;
  logic             in_vld_p0;
  logic             in_ok_p0;
  logic             cand_ok_p0;
  logic             act_p0;
  logic             disp_p0;
  logic             cap_p0;
  logic             takeA_p0, takeL_p0, takeB_p0;

  always_comb begin
    in_rs_p0 = class_to_rs(inClass);
    sk_rs_p0 = class_to_rs(sClass);
    in_vld_p0 = (in_rs_p0 != NONE);

    // Credit check for the raw input; drives stall even when the skid is
    // the real candidate (stall is already high in that case).
    case (in_rs_p0)
      ALU:     in_ok_p0 = availA;
      LS:      in_ok_p0 = availL;
      BR:      in_ok_p0 = availB;
      default: in_ok_p0 = 1'b0;
    endcase

    // An occupied skid always goes first so program order is kept.
    cand_rs_p0  = sv ? sk_rs_p0 : in_rs_p0;
    cand_pay_p0 = sv ? sPay     : inPayload;

    case (cand_rs_p0)
      ALU:     cand_ok_p0 = availA;
      LS:      cand_ok_p0 = availL;
      BR:      cand_ok_p0 = availB;
      default: cand_ok_p0 = 1'b0;
    endcase

    // Decisions use start-of-cycle credit only; freeNum has no path here.
    act_p0  = rdy & ~misTaken;
    disp_p0 = act_p0 & (cand_rs_p0 != NONE) & cand_ok_p0;
    cap_p0  = act_p0 & ~sv & in_vld_p0 & ~cand_ok_p0;

    takeA_p0 = disp_p0 & (cand_rs_p0 == ALU);
    takeL_p0 = disp_p0 & (cand_rs_p0 == LS);
    takeB_p0 = disp_p0 & (cand_rs_p0 == BR);
  end

  assign stall = ~rdy | sv | (in_vld_p0 & ~in_ok_p0);

  credit_counter #(.SIZE(ALU_SIZE)) u_cnt_alu (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .take    (takeA_p0),
    .freeNum (aluFreeNum),
    .credit  (cA),
    .avail   (availA)
  );

  credit_counter #(.SIZE(LS_SIZE)) u_cnt_ls (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .take    (takeL_p0),
    .freeNum (lsFreeNum),
    .credit  (cL),
    .avail   (availL)
  );

  credit_counter #(.SIZE(BR_SIZE)) u_cnt_br (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .take    (takeB_p0),
    .freeNum (brFreeNum),
    .credit  (cB),
    .avail   (availB)
  );

  // Stage p1: registered strobes, payload and skid control
  always_ff @(posedge clk) begin
    if (rst) begin
      aluEn      <= 1'b0;
      lsEn       <= 1'b0;
      brEn       <= 1'b0;
      outPayload <= '0;
      sv         <= 1'b0;
    end else if (rdy) begin
      aluEn <= takeA_p0;
      lsEn  <= takeL_p0;
      brEn  <= takeB_p0;
      if (disp_p0) begin
        outPayload <= cand_pay_p0;
      end
      if (misTaken) begin
        sv <= 1'b0;
      end else if (cap_p0) begin
        sv <= 1'b1;
      end else if (sv && disp_p0) begin
        sv <= 1'b0;
      end
    end else begin
      // Strobes are single-cycle; a frozen pipeline must not repeat a write.
      aluEn <= 1'b0;
      lsEn  <= 1'b0;
      brEn  <= 1'b0;
    end
  end

  // Skid data carries no reset; sv qualifies it.
  always_ff @(posedge clk) begin
    if (cap_p0) begin
      sClass <= inClass;
      sPay   <= inPayload;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && rdy && sv) begin
      assert (inClass == ClassNOP)
        else $error("dispatch_ctrl: input class %b arrived while skid occupied", inClass);
    end
  end
`endif

endmodule
